// File: rtl/mask_filter_pkg.sv
// Shared constants and helpers for the mask filter and its population counter.
package mask_filter_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Width needed to hold a count from 0 up to and including w.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mask_filter_popcount.sv
// Combinational population count: number of 1 bits in data, range 0..WIDTH.
module popcount
    import mask_filter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]              data,
    output logic [count_width(WIDTH)-1:0] count
);

    localparam int CW = count_width(WIDTH);

    // Sum every bit; the count is wide enough that an all-ones word does not wrap.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CW'(data[i]);
        end
    end

endmodule

// File: rtl/mask_filter.sv
// Mask filter: combinational in & mask, plus a registered copy with
// population count, all-zero flag and "every mask bit present" flag.
module mask_filter
    import mask_filter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              in,
    input  logic [WIDTH-1:0]              mask,
    input  logic                          in_valid,
    output logic [WIDTH-1:0]              out,
    output logic [WIDTH-1:0]              out_q,
    output logic                          out_valid,
    output logic [count_width(WIDTH)-1:0] ones,
    output logic                          zero,
    output logic                          all_set
);

    localparam int CW = count_width(WIDTH);

    logic [CW-1:0] masked_ones;

    // The filtered word never depends on clock, reset or in_valid.
    assign out = in & mask;

    popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .data  (out),
        .count (masked_ones)
    );

    // Capture the filtered word and its flags whenever in_valid is sampled high;
    // otherwise hold the last result and drop out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            ones      <= '0;
            zero      <= 1'b1;
            all_set   <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            out_q     <= out;
            ones      <= masked_ones;
            zero      <= (out == '0);
            all_set   <= (out == mask);
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mask_filter.sv
// Directed and random self-checking bench for mask_filter (WIDTH = 32).
module tb_mask_filter;

    localparam int W  = 32;
    localparam int CW = 6;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  in;
    logic [W-1:0]  mask;
    logic          in_valid;
    logic [W-1:0]  out;
    logic [W-1:0]  out_q;
    logic          out_valid;
    logic [CW-1:0] ones;
    logic          zero;
    logic          all_set;

    int checks;
    int errors;

    // Reference state for the random phase.
    logic [W-1:0]  exp_q;
    logic [CW-1:0] exp_ones;
    logic          exp_zero;
    logic          exp_all;
    logic          exp_valid;

    mask_filter #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .mask      (mask),
        .in_valid  (in_valid),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid),
        .ones      (ones),
        .zero      (zero),
        .all_set   (all_set)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkRegs(input string tag, input logic [W-1:0] q, input int n,
                             input logic z, input logic a, input logic v);
        checkOutput({tag, ".out_q"}, 64'(out_q), 64'(q));
        checkOutput({tag, ".ones"}, 64'(ones), 64'(n));
        checkOutput({tag, ".zero"}, 64'(zero), 64'(z));
        checkOutput({tag, ".all_set"}, 64'(all_set), 64'(a));
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    endtask

    // Drive inputs just after a falling edge, well away from the capture edge.
    task automatic applyStimulus(input logic [W-1:0] d, input logic [W-1:0] m, input logic v);
        @(negedge clk);
        in       = d;
        mask     = m;
        in_valid = v;
    endtask

    task automatic toCapture();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] rd;
        logic [W-1:0] rm;
        logic         rv;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in       = 32'h1234_5678;
        mask     = 32'hffff_ffff;
        in_valid = 1'b1;

        // Reset holds registers even with in_valid high and clock running.
        toCapture();
        checkRegs("reset", 32'h0, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("reset.out", 64'(out), 64'h1234_5678);

        // First capture is the first edge after release with in_valid high.
        applyStimulus(32'hffff_ffff, 32'hf0f0_f0f0, 1'b1);
        rst_n = 1'b1;
        #1;
        checkOutput("f0.out", 64'(out), 64'hf0f0_f0f0);
        checkRegs("f0.pre", 32'h0, 0, 1'b1, 1'b0, 1'b0);
        toCapture();
        checkRegs("f0", 32'hf0f0_f0f0, 16, 1'b0, 1'b1, 1'b1);

        applyStimulus(32'h1231_2312, 32'h50f3_7431, 1'b1);
        #1;
        checkOutput("mix.out", 64'(out), 64'h1031_2010);
        toCapture();
        checkRegs("mix", 32'h1031_2010, 6, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle with a valid result held.
        applyStimulus(32'h0f0f_0f0f, 32'h00ff_00ff, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkRegs("midrst", 32'h0, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("midrst.out", 64'(out), 64'h000f_000f);
        toCapture();
        checkRegs("midrst.edge", 32'h0, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Empty mask, then full mask with all-ones data.
        applyStimulus(32'hdead_beef, 32'h0, 1'b1);
        #1;
        checkOutput("m0.out", 64'(out), 64'h0);
        toCapture();
        checkRegs("m0", 32'h0, 0, 1'b1, 1'b1, 1'b1);
        applyStimulus(32'hffff_ffff, 32'hffff_ffff, 1'b1);
        #1;
        checkOutput("m1.out", 64'(out), 64'hffff_ffff);
        toCapture();
        checkRegs("m1", 32'hffff_ffff, 32, 1'b0, 1'b1, 1'b1);

        // Three back-to-back captures, then idle with results held.
        applyStimulus(32'h0000_000f, 32'hffff_ffff, 1'b1);
        toCapture();
        checkRegs("b2b.a", 32'h0000_000f, 4, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'haaaa_aaaa, 32'h0000_ffff, 1'b1);
        toCapture();
        checkRegs("b2b.b", 32'h0000_aaaa, 8, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'hffff_0000, 32'hff00_0000, 1'b1);
        toCapture();
        checkRegs("b2b.c", 32'hff00_0000, 8, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'h1111_1111, 32'h1111_1111, 1'b0);
        #1;
        checkOutput("idle.out", 64'(out), 64'h1111_1111);
        toCapture();
        checkRegs("idle1", 32'hff00_0000, 8, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h0, 32'hffff_ffff, 1'b0);
        toCapture();
        checkRegs("idle2", 32'hff00_0000, 8, 1'b0, 1'b1, 1'b0);

        // Random traffic against a reference model.
        exp_q     = 32'hff00_0000;
        exp_ones  = 6'd8;
        exp_zero  = 1'b0;
        exp_all   = 1'b1;
        exp_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            rd = $urandom;
            rm = (i % 7 == 0) ? 32'h0 : $urandom;
            rv = ($urandom_range(0, 3) != 0);
            applyStimulus(rd, rm, rv);
            #1;
            checkOutput("rnd.out", 64'(out), 64'(rd & rm));
            if (rv) begin
                exp_q     = rd & rm;
                exp_ones  = CW'($countones(rd & rm));
                exp_zero  = ((rd & rm) == 32'h0);
                exp_all   = ((rd & rm) == rm);
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            toCapture();
            checkRegs("rnd", exp_q, int'(exp_ones), exp_zero, exp_all, exp_valid);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mask_filter.md
MASK_FILTER -- requirements
Module: mask_filter

Interface
REQ-001 Parameter WIDTH, default 32: data, mask and result bit width; legal range 1..64.
REQ-002 Port clk  input  1: single clock; all registered state updates on its rising edge.
REQ-003 Port rst_n  input  1: reset, asynchronous, active-low; this is the only reset.
REQ-004 Port in  input  WIDTH: data word to be filtered.
REQ-005 Port mask  input  WIDTH: bit mask; a 1 keeps the corresponding bit of in.
REQ-006 Port out  output  WIDTH: combinational filtered word.
REQ-007 Port in_valid  input  1: qualifies in/mask for capture into the registered stage.
REQ-008 Port out_q  output  WIDTH: registered filtered word.
REQ-009 Port out_valid  output  1: out_q and its flags hold a captured result.
REQ-010 Port ones  output  $clog2(WIDTH+1): registered count of 1 bits in out_q.
REQ-011 Port zero  output  1: registered flag, out_q is all zeros.
REQ-012 Port all_set  output  1: registered flag, every mask bit was also set in in (in & mask == mask).

Function
REQ-013 out SHALL equal the bitwise AND of in and mask at all times, purely combinational, with no dependence on clk, rst_n or in_valid.
REQ-014 out SHALL settle within the same time step as an input change; no latches.
REQ-015 On a rising clk edge with in_valid=1, out_q SHALL load in & mask; ones, zero and all_set SHALL load values computed from the same in and mask; out_valid SHALL become 1.
REQ-016 On a rising clk edge with in_valid=0, out_q, ones, zero and all_set SHALL hold; out_valid SHALL become 0.
REQ-017 Capture latency: 1 cycle from in_valid sampled high to out_valid high.
REQ-018 Back-to-back in_valid SHALL capture every cycle, with no bubbles or stalls.
REQ-019 ones SHALL range 0..WIDTH inclusive; WIDTH ones SHALL not wrap.
REQ-020 mask all zeros: out=0, zero=1, all_set=1, ones=0.
REQ-021 mask all ones: out equals in.
REQ-022 all_set and zero SHALL be mutually consistent with out_q and ones in every captured cycle.

Reset
REQ-023 While rst_n=0, out_q=0, ones=0, zero=1, all_set=0 and out_valid=0, asynchronously and independent of clk.
REQ-024 Reset deassertion SHALL take effect synchronously: the first capture is the first rising edge with rst_n=1 and in_valid=1.
REQ-025 Reset SHALL have no effect on out (REQ-013).
REQ-026 Reset asserted mid-stream SHALL discard the pending capture; out_valid=0 immediately.

Structure
REQ-027 Package mask_filter_pkg SHALL hold the default WIDTH constant and a function returning the counter width $clog2(WIDTH+1).
REQ-028 The population count SHALL be a separate parameterised combinational sub-module named popcount (input WIDTH bits, output count).
REQ-029 One always_ff block for the registered stage; combinational logic in continuous assignments or always_comb.

Verification
REQ-030 in=ffffffff, mask=f0f0f0f0 -> out=f0f0f0f0 after 1 time unit; after a clk edge with in_valid=1: out_q=f0f0f0f0, ones=16, zero=0, all_set=1.
REQ-031 in=12312312, mask=50f37431 -> out=10312010; captured ones=6, all_set=0, zero=0.
REQ-032 rst_n=0 mid-operation with out_valid=1 -> out_q=0, out_valid=0, zero=1 before the next clk edge; out still tracks in & mask.
REQ-033 mask=00000000 with arbitrary in, captured -> out=0, ones=0, zero=1, all_set=1; then mask=ffffffff, in=ffffffff -> ones=32.
REQ-034 in_valid pulsed for 3 consecutive cycles with distinct words, then low -> three consecutive results each one cycle later, out_valid drops after the last, and values hold.
REQ-035 Random in/mask for 1000 cycles -> out === in & mask every cycle; registered outputs match the model, delayed by one cycle.
